// File: rtl/sys_bridge_n_if.sv
// sys_bridge_n_if: bus bundle between the processor, the bridge and its slaves.
//   Processor side : pr_req, pr_rw, pr_addr, pr_be, pr_wdata -> bridge
//                    pr_rdata, pr_ready, pr_err            <- bridge
//   Peripheral side: adr_o, dat_o, we_o, sel_o, stb_o       <- bridge
//                    ack_i, dat_i (slave k at [32k +: 32])  -> bridge
// Modports:
//   master : bridge view (drives the peripheral strobe bus and the processor response)
//   slave  : environment view (processor requests and peripheral responses)
interface sys_bridge_n_if #(
  parameter int unsigned NUM_SLAVES = 4,
  parameter int unsigned SLV_ADR_W  = 2
);
  logic                      pr_req;
  logic                      pr_rw;
  logic [31:0]               pr_addr;
  logic [3:0]                pr_be;
  logic [31:0]               pr_wdata;
  logic [31:0]               pr_rdata;
  logic                      pr_ready;
  logic                      pr_err;
  logic [SLV_ADR_W-1:0]      adr_o;
  logic [31:0]               dat_o;
  logic                      we_o;
  logic [3:0]                sel_o;
  logic [NUM_SLAVES-1:0]     stb_o;
  logic [NUM_SLAVES-1:0]     ack_i;
  logic [32*NUM_SLAVES-1:0]  dat_i;

  modport master (
    input  pr_req, pr_rw, pr_addr, pr_be, pr_wdata,
    output pr_rdata, pr_ready, pr_err,
    output adr_o, dat_o, we_o, sel_o, stb_o,
    input  ack_i, dat_i
  );

  modport slave (
    output pr_req, pr_rw, pr_addr, pr_be, pr_wdata,
    input  pr_rdata, pr_ready, pr_err,
    input  adr_o, dat_o, we_o, sel_o, stb_o,
    output ack_i, dat_i
  );
endinterface

// File: rtl/sys_bridge_n.sv
// sys_bridge_n: N-slave processor-to-peripheral bridge.
//   Decodes the I/O window pr_addr[31:16]==IO_BASE, slave index pr_addr[SEL_LSB +: 3],
//   drives a registered one-hot strobe to the selected slave, waits for its
//   acknowledge and returns read data with a one-cycle pr_ready pulse.
// Ports:
//   clk   : system clock, rising edge
//   reset : asynchronous, active-high
//   bus   : sys_bridge_n_if.master (processor request/response + slave strobe bus)
// Configuration macro:
//   SYS_BRIDGE_TIMEOUT_EN : builds the acknowledge watchdog; a missing acknowledge
//   after TIMEOUT strobe cycles or an unmapped address completes with pr_err=1.
//   Undefined: ACCESS waits indefinitely and pr_err stays 0; unmapped addresses
//   still complete with pr_ready=1 and pr_rdata=0.
module sys_bridge_n #(
  parameter int unsigned NUM_SLAVES = 4,
  parameter int unsigned SLV_ADR_W  = 2,
  parameter int unsigned SEL_LSB    = 4,
  parameter logic [15:0] IO_BASE    = 16'h7F00,
  parameter int unsigned TIMEOUT    = 16
) (
  input logic            clk,
  input logic            reset,
  sys_bridge_n_if.master bus
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  localparam logic [3:0] NS = 4'(NUM_SLAVES);

`ifdef SYS_BRIDGE_TIMEOUT_EN
  localparam logic       ERR_EN  = 1'b1;
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);
`else
  localparam logic       ERR_EN  = 1'b0;
`endif

  state_t                state, state_d;
  logic [2:0]            idx, idx_d;
  logic [2:0]            req_idx;
  logic                  mapped;
  logic                  ack_hit;
  logic                  expired;
  logic [31:0]           rd_sel;

  logic [SLV_ADR_W-1:0]  adr_d;
  logic [31:0]           dat_d;
  logic                  we_d;
  logic [3:0]            sel_d;
  logic [NUM_SLAVES-1:0] stb_d;
  logic [31:0]           rdata_d;
  logic                  ready_d;
  logic                  err_d;

  assign req_idx = bus.pr_addr[SEL_LSB +: 3];
  assign mapped  = (bus.pr_addr[31:16] == IO_BASE) && ({1'b0, req_idx} < NS);

  // Only the selected slave's acknowledge and data are looked at.
  always_comb begin
    ack_hit = 1'b0;
    rd_sel  = '0;
    for (int unsigned k = 0; k < NUM_SLAVES; k++) begin
      if (32'(idx) == k) begin
        ack_hit = bus.ack_i[k];
        rd_sel  = bus.dat_i[32*k +: 32];
      end
    end
  end

`ifdef SYS_BRIDGE_TIMEOUT_EN
  logic [7:0] cnt, cnt_d;

  assign expired = (cnt == TO_LAST);

  always_comb begin
    cnt_d = cnt;
    if (state == IDLE) begin
      cnt_d = '0;
    end else if (state == ACCESS && !ack_hit) begin
      cnt_d = cnt + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else begin
      cnt <= cnt_d;
    end
  end
`else
  assign expired = 1'b0;
`endif

  always_comb begin
    state_d = state;
    idx_d   = idx;
    adr_d   = bus.adr_o;
    dat_d   = bus.dat_o;
    we_d    = bus.we_o;
    sel_d   = bus.sel_o;
    stb_d   = '0;
    rdata_d = bus.pr_rdata;
    ready_d = 1'b0;
    err_d   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.pr_req) begin
          if (mapped) begin
            state_d = ACCESS;
            idx_d   = req_idx;
            adr_d   = bus.pr_addr[2 +: SLV_ADR_W];
            dat_d   = bus.pr_wdata;
            we_d    = bus.pr_rw;
            sel_d   = bus.pr_be;
            for (int unsigned k = 0; k < NUM_SLAVES; k++) begin
              stb_d[k] = (32'(req_idx) == k);
            end
          end else begin
            state_d = DONE;
            ready_d = 1'b1;
            err_d   = ERR_EN;
            rdata_d = '0;
          end
        end
      end
      ACCESS: begin
        // Acknowledge is checked first so it wins over a simultaneous timeout.
        if (ack_hit) begin
          state_d = DONE;
          ready_d = 1'b1;
          rdata_d = bus.we_o ? 32'h0 : rd_sel;
        end else if (expired) begin
          state_d = DONE;
          ready_d = 1'b1;
          err_d   = 1'b1;
          rdata_d = '0;
        end else begin
          stb_d = bus.stb_o;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  // Every output is a register; the next values above decide what they load.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx          <= '0;
      bus.adr_o    <= '0;
      bus.dat_o    <= '0;
      bus.we_o     <= 1'b0;
      bus.sel_o    <= '0;
      bus.stb_o    <= '0;
      bus.pr_rdata <= '0;
      bus.pr_ready <= 1'b0;
      bus.pr_err   <= 1'b0;
    end else begin
      idx          <= idx_d;
      bus.adr_o    <= adr_d;
      bus.dat_o    <= dat_d;
      bus.we_o     <= we_d;
      bus.sel_o    <= sel_d;
      bus.stb_o    <= stb_d;
      bus.pr_rdata <= rdata_d;
      bus.pr_ready <= ready_d;
      bus.pr_err   <= err_d;
    end
  end

  // Address bits outside the decoded fields and the watchdog length in builds
  // without the watchdog are intentionally not used.
  logic unused_bits;
  assign unused_bits = ^{bus.pr_addr, 8'(TIMEOUT)};

endmodule

// File: tb/tb_sys_bridge_n.sv
// tb_sys_bridge_n: directed self-checking bench for sys_bridge_n.
//   Cycle n is the interval after rising edge n; the request is sampled at edge 0.
//   Inputs change and outputs are sampled 1 ns after a rising edge.
module tb_sys_bridge_n;

`ifdef SYS_BRIDGE_TIMEOUT_EN
  localparam logic ERR_EXP = 1'b1;
`else
  localparam logic ERR_EXP = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   n;

  always #5 clk = ~clk;

  sys_bridge_n_if #(.NUM_SLAVES(4), .SLV_ADR_W(2)) bus ();

  sys_bridge_n #(
    .NUM_SLAVES(4),
    .SLV_ADR_W (2),
    .SEL_LSB   (4),
    .IO_BASE   (16'h7F00),
    .TIMEOUT   (16)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a request in the current (idle) cycle; returns in cycle 1 with pr_req low.
  task automatic start(input logic rw, input logic [31:0] addr,
                       input logic [3:0] be, input logic [31:0] wdata);
    bus.pr_req   = 1'b1;
    bus.pr_rw    = rw;
    bus.pr_addr  = addr;
    bus.pr_be    = be;
    bus.pr_wdata = wdata;
    tick();
    bus.pr_req   = 1'b0;
  endtask

  initial begin
    bus.pr_req   = 1'b0;
    bus.pr_rw    = 1'b0;
    bus.pr_addr  = '0;
    bus.pr_be    = '0;
    bus.pr_wdata = '0;
    bus.ack_i    = '0;
    bus.dat_i    = '0;

    // Reset values
    tick();
    check("rst_rdata", 64'(bus.pr_rdata), 64'h0);
    check("rst_ready", 64'(bus.pr_ready), 64'h0);
    check("rst_err",   64'(bus.pr_err),   64'h0);
    check("rst_stb",   64'(bus.stb_o),    64'h0);
    check("rst_adr",   64'(bus.adr_o),    64'h0);
    check("rst_dat",   64'(bus.dat_o),    64'h0);
    check("rst_we",    64'(bus.we_o),     64'h0);
    check("rst_sel",   64'(bus.sel_o),    64'h0);
    reset = 1'b0;
    tick();

    // Read slave 1, offset 1, acknowledged in the first ACCESS cycle
    start(1'b0, 32'h7F00_0014, 4'hF, 32'h0);
    check("rd1_stb",   64'(bus.stb_o),    64'h2);
    check("rd1_adr",   64'(bus.adr_o),    64'h1);
    check("rd1_we",    64'(bus.we_o),     64'h0);
    check("rd1_rdy_c1", 64'(bus.pr_ready), 64'h0);
    bus.ack_i = 4'b0010;
    bus.dat_i[32 +: 32] = 32'h1234_5678;
    tick();
    bus.ack_i = '0;
    check("rd1_ready", 64'(bus.pr_ready), 64'h1);
    check("rd1_rdata", 64'(bus.pr_rdata), 64'h1234_5678);
    check("rd1_err",   64'(bus.pr_err),   64'h0);
    check("rd1_stb_c2", 64'(bus.stb_o),   64'h0);
    tick();
    check("rd1_rdy_c3", 64'(bus.pr_ready), 64'h0);

    // Write slave 3, offset 2, acknowledge after 3 wait cycles
    start(1'b1, 32'h7F00_0038, 4'b0011, 32'hCAFE_F00D);
    check("wr_stb",    64'(bus.stb_o),    64'h8);
    check("wr_we",     64'(bus.we_o),     64'h1);
    check("wr_sel",    64'(bus.sel_o),    64'h3);
    check("wr_dat",    64'(bus.dat_o),    64'hCAFE_F00D);
    check("wr_adr",    64'(bus.adr_o),    64'h2);
    bus.dat_i[96 +: 32] = 32'hFFFF_FFFF;
    tick();
    tick();
    tick();
    check("wr_stb_c4", 64'(bus.stb_o),    64'h8);
    check("wr_rdy_c4", 64'(bus.pr_ready), 64'h0);
    bus.ack_i = 4'b1000;
    tick();
    bus.ack_i = '0;
    check("wr_ready",  64'(bus.pr_ready), 64'h1);
    check("wr_rdata",  64'(bus.pr_rdata), 64'h0);
    check("wr_err",    64'(bus.pr_err),   64'h0);
    tick();

    // Unmapped: outside the I/O window
    start(1'b0, 32'h1000_0000, 4'hF, 32'h0);
    check("um1_ready", 64'(bus.pr_ready), 64'h1);
    check("um1_err",   64'(bus.pr_err),   64'(ERR_EXP));
    check("um1_stb",   64'(bus.stb_o),    64'h0);
    check("um1_rdata", 64'(bus.pr_rdata), 64'h0);
    check("um1_we_hold",  64'(bus.we_o),  64'h1);
    check("um1_dat_hold", 64'(bus.dat_o), 64'hCAFE_F00D);
    tick();
    check("um1_rdy_c2", 64'(bus.pr_ready), 64'h0);

    // Unmapped: index 5 with four slaves
    start(1'b0, 32'h7F00_0050, 4'hF, 32'h0);
    check("um5_ready", 64'(bus.pr_ready), 64'h1);
    check("um5_err",   64'(bus.pr_err),   64'(ERR_EXP));
    check("um5_stb",   64'(bus.stb_o),    64'h0);
    tick();

    // Slave 0 acknowledges while slave 2 is selected
    bus.dat_i[0 +: 32]  = 32'hDEAD_0000;
    bus.dat_i[64 +: 32] = 32'hA5A5_0002;
    start(1'b0, 32'h7F00_0020, 4'hF, 32'h0);
    check("ign_stb",   64'(bus.stb_o),    64'h4);
    bus.ack_i = 4'b0001;
    tick();
    check("ign_rdy",   64'(bus.pr_ready), 64'h0);
    check("ign_stb2",  64'(bus.stb_o),    64'h4);
    bus.ack_i = 4'b0100;
    tick();
    bus.ack_i = '0;
    check("ign_ready", 64'(bus.pr_ready), 64'h1);
    check("ign_rdata", 64'(bus.pr_rdata), 64'hA5A5_0002);
    tick();

`ifdef SYS_BRIDGE_TIMEOUT_EN
    // No acknowledge: strobe held exactly 16 cycles, then error response
    start(1'b0, 32'h7F00_0010, 4'hF, 32'h0);
    n = 0;
    while (bus.stb_o != 4'b0 && n < 40) begin
      n++;
      tick();
    end
    check("to_stb_cycles", 64'(n),        64'd16);
    check("to_ready",  64'(bus.pr_ready), 64'h1);
    check("to_err",    64'(bus.pr_err),   64'h1);
    check("to_rdata",  64'(bus.pr_rdata), 64'h0);
    tick();

    // Acknowledge in the 16th strobe cycle wins over the timeout
    bus.dat_i[32 +: 32] = 32'h0BAD_CAFE;
    start(1'b0, 32'h7F00_0010, 4'hF, 32'h0);
    for (int i = 1; i < 16; i++) tick();
    check("to16_stb",  64'(bus.stb_o),    64'h2);
    bus.ack_i = 4'b0010;
    tick();
    bus.ack_i = '0;
    check("to16_ready", 64'(bus.pr_ready), 64'h1);
    check("to16_err",   64'(bus.pr_err),   64'h0);
    check("to16_rdata", 64'(bus.pr_rdata), 64'h0BAD_CAFE);
    tick();
`else
    // Without the watchdog the bridge waits indefinitely for acknowledge
    bus.dat_i[32 +: 32] = 32'h0BAD_CAFE;
    start(1'b0, 32'h7F00_0010, 4'hF, 32'h0);
    for (int i = 1; i < 40; i++) tick();
    check("wait_stb",   64'(bus.stb_o),    64'h2);
    check("wait_rdy",   64'(bus.pr_ready), 64'h0);
    bus.ack_i = 4'b0010;
    tick();
    bus.ack_i = '0;
    check("wait_ready", 64'(bus.pr_ready), 64'h1);
    check("wait_err",   64'(bus.pr_err),   64'h0);
    check("wait_rdata", 64'(bus.pr_rdata), 64'h0BAD_CAFE);
    tick();
`endif

    // Reset asserted during ACCESS takes effect without a clock edge
    start(1'b0, 32'h7F00_0000, 4'hF, 32'h0);
    check("ra_stb_pre", 64'(bus.stb_o),   64'h1);
    #2;
    reset = 1'b1;
    #1;
    check("ra_stb",    64'(bus.stb_o),    64'h0);
    check("ra_ready",  64'(bus.pr_ready), 64'h0);
    check("ra_err",    64'(bus.pr_err),   64'h0);
    tick();
    reset = 1'b0;
    tick();

    // Normal read after reset
    bus.dat_i[0 +: 32] = 32'h5555_AAAA;
    start(1'b0, 32'h7F00_0004, 4'hF, 32'h0);
    check("pr_stb",    64'(bus.stb_o),    64'h1);
    check("pr_adr",    64'(bus.adr_o),    64'h1);
    bus.ack_i = 4'b0001;
    tick();
    bus.ack_i = '0;
    check("pr_ready",  64'(bus.pr_ready), 64'h1);
    check("pr_rdata",  64'(bus.pr_rdata), 64'h5555_AAAA);
    check("pr_err",    64'(bus.pr_err),   64'h0);
    tick();
    check("pr_rdy_end", 64'(bus.pr_ready), 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
